// File: rtl/fp_operand_convert_pipe.sv
// fp_operand_convert_pipe
// Front end for the div/sqrt datapath. Widens up to two packed FP operands
// (double, single or half) to double, classifies them in their source format,
// and carries each request and its tag through PIPE_STAGES elastic stages.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds valid and the payload stable until that edge. Ready
// may depend combinationally on the downstream ready. out_valid never drops
// and the outputs never change until the result is consumed, except on flush
// or reset.
module fp_operand_convert_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int TAGW        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     op_a,
    input  logic [63:0]     op_b,
    input  logic [1:0]      fmt,
    input  logic            op_type,
    input  logic            neg_a,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     float_a,
    output logic [63:0]     float_b,
    output logic [3:0]      cls_a,
    output logic [3:0]      cls_b,
    output logic            fmt_err,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    typedef struct packed {
        logic [3:0]  cls;   // {nan, inf, sub, zero}
        logic [63:0] val;   // double
    } conv_t;

    typedef struct packed {
        logic [63:0]     float_a;
        logic [63:0]     float_b;
        logic [3:0]      cls_a;
        logic [3:0]      cls_b;
        logic            fmt_err;
        logic [TAGW-1:0] tag;
    } payload_t;

    // Widen one operand to double. Subnormals keep their mantissa unshifted
    // under a zero exponent; they are only flagged in the class bits.
    // The reserved format is handled as double.
    function automatic conv_t convert(input logic [63:0] op, input logic [1:0] f,
                                      input logic neg);
        conv_t       r;
        logic        e_zero;
        logic        e_ones;
        logic        m_zero;
        logic [10:0] exp_d;
        logic [51:0] man_d;
        case (f)
            2'b01: begin
                e_zero = (op[62:55] == 8'h00);
                e_ones = (op[62:55] == 8'hFF);
                m_zero = (op[54:32] == 23'd0);
                exp_d  = e_zero ? 11'd0 : e_ones ? 11'h7FF : {3'b000, op[62:55]} + 11'd896;
                man_d  = {op[54:32], 29'd0};
            end
            2'b10: begin
                e_zero = (op[62:58] == 5'h00);
                e_ones = (op[62:58] == 5'h1F);
                m_zero = (op[57:48] == 10'd0);
                exp_d  = e_zero ? 11'd0 : e_ones ? 11'h7FF : {6'b000000, op[62:58]} + 11'd1008;
                man_d  = {op[57:48], 42'd0};
            end
            default: begin
                e_zero = (op[62:52] == 11'h000);
                e_ones = (op[62:52] == 11'h7FF);
                m_zero = (op[51:0] == 52'd0);
                exp_d  = op[62:52];
                man_d  = op[51:0];
            end
        endcase
        r.val = {op[63] ^ neg, exp_d, man_d};
        r.cls = {e_ones & ~m_zero, e_ones & m_zero, e_zero & ~m_zero, e_zero & m_zero};
        return r;
    endfunction

    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] ready;
    payload_t               stage_q [PIPE_STAGES];
    payload_t               in_payload;
    conv_t                  conv_a;
    conv_t                  conv_b;

    // Convert the incoming operands; sqrt reuses converted A as B.
    always_comb begin
        conv_a                = convert(op_a, fmt, neg_a);
        conv_b                = op_type ? conv_a : convert(op_b, fmt, 1'b0);
        in_payload.float_a    = conv_a.val;
        in_payload.float_b    = conv_b.val;
        in_payload.cls_a      = conv_a.cls;
        in_payload.cls_b      = conv_b.cls;
        in_payload.fmt_err    = (fmt == 2'b11);
        in_payload.tag        = in_tag;
    end

    // Stage k can load when it, or any stage after it, has a hole, or the
    // consumer takes the last stage this cycle (flattened ready chain).
    always_comb begin
        ready = '0;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            ready[k] = out_ready | (|((~valid_q) >> k));
        end
    end

    // Advance the elastic stages; flush kills every in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                valid_q[0] <= in_valid & ~flush;
                if (in_valid && !flush) begin
                    stage_q[0] <= in_payload;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    assign in_ready  = ready[0] & ~flush;
    assign out_valid = valid_q[PIPE_STAGES-1];
    assign busy      = |valid_q;
    assign float_a   = stage_q[PIPE_STAGES-1].float_a;
    assign float_b   = stage_q[PIPE_STAGES-1].float_b;
    assign cls_a     = stage_q[PIPE_STAGES-1].cls_a;
    assign cls_b     = stage_q[PIPE_STAGES-1].cls_b;
    assign fmt_err   = stage_q[PIPE_STAGES-1].fmt_err;
    assign out_tag   = stage_q[PIPE_STAGES-1].tag;

endmodule

// File: tb/tb_fp_operand_convert_pipe.sv
// Directed bench for fp_operand_convert_pipe (PIPE_STAGES=2, TAGW=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// or on the falling edge.
module tb_fp_operand_convert_pipe;
    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     op_a;
    logic [63:0]     op_b;
    logic [1:0]      fmt;
    logic            op_type;
    logic            neg_a;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     float_a;
    logic [63:0]     float_b;
    logic [3:0]      cls_a;
    logic [3:0]      cls_b;
    logic            fmt_err;
    logic [TAGW-1:0] out_tag;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [TAGW-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    fp_operand_convert_pipe #(.PIPE_STAGES(2), .TAGW(TAGW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .fmt(fmt), .op_type(op_type), .neg_a(neg_a),
        .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .float_a(float_a), .float_b(float_b), .cls_a(cls_a), .cls_b(cls_b),
        .fmt_err(fmt_err), .out_tag(out_tag), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // driver: offer one request, expect it to be accepted at the next edge
    task automatic send(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic ot, input logic ng, input logic [TAGW-1:0] tg);
        fmt = f; op_a = a; op_b = b; op_type = ot; neg_a = ng; in_tag = tg;
        in_valid = 1'b1;
        #1;
        chk("send_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max_cycles);
        for (int i = 0; i < max_cycles && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAGW-1:0] e_tag;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0;
        fmt = 2'b00; op_type = 1'b0; neg_a = 1'b0; in_tag = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_float_a", float_a, 64'd0);
        chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // 1: single precision, latency 2
        send(2'b01, 64'h3F800000_DEADBEEF, 64'hC0000000_00000000, 1'b0, 1'b0, 4'd1);
        chk("t1_lat1", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("t1_lat2", {63'd0, out_valid}, 64'd1);
        chk("t1_float_a", float_a, 64'h3FF0000000000000);
        chk("t1_float_b", float_b, 64'hC000000000000000);
        chk("t1_cls", {56'd0, cls_a, cls_b}, 64'd0);
        chk("t1_tag", {60'd0, out_tag}, 64'd1);
        @(posedge clk); #1;
        chk("t1_consumed", {63'd0, out_valid}, 64'd0);

        // 2: half precision, inf and subnormal
        send(2'b10, 64'h7C00_1234_5678_9ABC, 64'h0001_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'd2);
        wait_out(5);
        chk("t2_float_a", float_a, 64'h7FF0000000000000);
        chk("t2_cls_a", {60'd0, cls_a}, 64'b0100);
        chk("t2_float_b", float_b, 64'h0000040000000000);
        chk("t2_cls_b", {60'd0, cls_b}, 64'b0010);
        @(posedge clk); #1;

        // 3: sqrt with negate, B replaced by A
        send(2'b00, 64'h4000000000000000, 64'h0000000000000123, 1'b1, 1'b1, 4'd3);
        wait_out(5);
        chk("t3_float_a", float_a, 64'hC000000000000000);
        chk("t3_float_b", float_b, 64'hC000000000000000);
        chk("t3_cls_b", {60'd0, cls_b}, 64'd0);
        @(posedge clk); #1;

        // 4: backpressure, ordering through a full pipe
        out_ready = 1'b0;
        send(2'b00, 64'h1, 64'h2, 1'b0, 1'b0, 4'd1); exp_q.push_back(4'd1);
        send(2'b00, 64'h3, 64'h4, 1'b0, 1'b0, 4'd2); exp_q.push_back(4'd2);
        in_tag = 4'd3; in_valid = 1'b1;
        #1;
        chk("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("t4_out_tag_head", {60'd0, out_tag}, 64'd1);
        @(posedge clk); #1;
        chk("t4_hold_ready", {63'd0, in_ready}, 64'd0);
        chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("t4_hold_tag", {60'd0, out_tag}, 64'd1);
        out_ready = 1'b1; exp_q.push_back(4'd3);
        #1;
        chk("t4_in_ready_rel", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() > 0) e_tag = exp_q.pop_front();
                else e_tag = 'x;
                chk("t4_order", {60'd0, out_tag}, {60'd0, e_tag});
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("t4_drained", 64'(exp_q.size()), 64'd0);
        chk("t4_no_dup", {63'd0, out_valid}, 64'd0);

        // 5: flush with two in flight and a simultaneous offer
        out_ready = 1'b0;
        send(2'b00, 64'h5, 64'h6, 1'b0, 1'b0, 4'd4);
        send(2'b00, 64'h7, 64'h8, 1'b0, 1'b0, 4'd5);
        chk("t5_busy", {63'd0, busy}, 64'd1);
        in_tag = 4'd6; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        #1;
        chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_busy_clr", {63'd0, busy}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("t5_not_taken", {63'd0, out_valid | busy}, 64'd0);

        // 6: asynchronous reset while a result is waiting, then reserved fmt
        out_ready = 1'b0;
        send(2'b01, 64'h3F800000_00000000, 64'h0, 1'b0, 1'b0, 4'd7);
        wait_out(5);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_float_a", float_a, 64'd0);
        chk("t6_rst_tag", {60'd0, out_tag}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        send(2'b11, 64'h4000000000000000, 64'h7FF8000000000001, 1'b0, 1'b0, 4'd8);
        wait_out(5);
        chk("t6_fmt_err", {63'd0, fmt_err}, 64'd1);
        chk("t6_float_a", float_a, 64'h4000000000000000);
        chk("t6_float_b", float_b, 64'h7FF8000000000001);
        chk("t6_cls_b", {60'd0, cls_b}, 64'b1000);
        chk("t6_tag", {60'd0, out_tag}, 64'd8);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
